// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
// Signed operation is selected at build time with MUL_SIGNED_EN.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mul_state_t;

  localparam int MUL_WD_DEFAULT = 8;

  function automatic int CNT_W(input int wd);
    return $clog2(wd) + 1;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One partial-product step: conditionally add the multiplicand to the
// running accumulator, keeping the carry as bit WD of the sum.
module mul_step
  import mul_pkg::*;
#(
  parameter int WD = MUL_WD_DEFAULT
) (
  input  logic [WD-1:0] acc,
  input  logic [WD-1:0] mcand,
  input  logic          mplr_lsb,
  output logic [WD:0]   sum
);

  logic [WD:0] addend;

  assign addend = mplr_lsb ? {1'b0, mcand} : '0;
  assign sum    = {1'b0, acc} + addend;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative WD-cycle shift-and-add multiplier with start/busy/done handshake.
// Define MUL_SIGNED_EN to treat X and Y as two's complement.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WD = MUL_WD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WD-1:0]   X,
  input  logic [WD-1:0]   Y,
  output logic            busy,
  output logic            done,
  output logic [2*WD-1:0] product
);

  localparam int CW = CNT_W(WD);

  mul_state_t    state;
  logic [WD-1:0] acc;
  logic [WD-1:0] mcand;
  logic [WD-1:0] mplr;
  logic [CW-1:0] cnt;
  logic [WD:0]   sum;
  logic          last;
  logic [WD-1:0] xa;
  logic [WD-1:0] ya;
  logic [2*WD-1:0] full;
  logic [2*WD-1:0] res;

  mul_step #(.WD(WD)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .mplr_lsb (mplr[0]),
    .sum      (sum)
  );

  assign busy = (state != IDLE);
  assign last = (cnt == CW'(WD - 1));
  assign full = {acc, mplr};

`ifdef MUL_SIGNED_EN
  logic neg;

  // -(-2^(WD-1)) wraps to itself, which is the correct unsigned magnitude
  assign xa  = X[WD-1] ? -X : X;
  assign ya  = Y[WD-1] ? -Y : Y;
  assign res = neg ? -full : full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg <= 1'b0;
    end else if (state == IDLE && start) begin
      neg <= X[WD-1] ^ Y[WD-1];
    end
  end
`else
  assign xa  = X;
  assign ya  = Y;
  assign res = full;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= xa;
            mplr  <= ya;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          // carry lands in acc MSB, low sum bit shifts into mplr
          acc  <= sum[WD:1];
          mplr <= {sum[0], mplr[WD-1:1]};
          cnt  <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
          end
        end
        DONE: begin
          product <= res;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
